// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard/redirect
// controls, the instruction-ROM port, and the F/D latch outputs.
interface fetch_if;
  logic        stall;
  logic        redirect_en;
  logic [11:0] redirect_target;
  logic [31:0] imem_data;
  logic [11:0] imem_addr;
  logic [31:0] o_insn;
  logic [11:0] o_PC_plus;
  logic        o_valid;
  logic [15:0] o_fetch_count;

  modport master (
    input  stall, redirect_en, redirect_target, imem_data,
    output imem_addr, o_insn, o_PC_plus, o_valid, o_fetch_count
  );

  modport slave (
    output stall, redirect_en, redirect_target, imem_data,
    input  imem_addr, o_insn, o_PC_plus, o_valid, o_fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, hides the one-cycle ROM latency,
// holds its output on hazard stalls and squashes wrong-path fetches on redirect.
module fetch_stage (
  input  logic    clock,
  input  logic    reset,
  fetch_if.master bus
);

  localparam int PC_W   = 12;
  localparam int INSN_W = 32;

  typedef enum logic [1:0] {FILL, RUN, STALL} state_t;

  state_t              state;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic [INSN_W-1:0]   hold;
  logic [15:0]         fetch_count;

  logic                valid_pre;
  logic [INSN_W-1:0]   insn_pre;
  logic                valid;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return PC_W'(pc + 1'b1);
  endfunction

  // Output select: ROM data while running, skid register while stalled.
  always_comb begin
    valid_pre = 1'b0;
    insn_pre  = '0;
    case (state)
      RUN: begin
        valid_pre = 1'b1;
        insn_pre  = bus.imem_data;
      end
      STALL: begin
        valid_pre = 1'b1;
        insn_pre  = hold;
      end
      default: begin
        valid_pre = 1'b0;
        insn_pre  = '0;
      end
    endcase
  end

  // A redirect in the same cycle marks the current output as wrong-path.
  assign valid             = valid_pre & ~bus.redirect_en;
  assign bus.o_valid       = valid;
  assign bus.o_insn        = valid ? insn_pre : '0;
  assign bus.o_PC_plus     = valid ? pc_inc(pc_d) : '0;
  assign bus.imem_addr     = pc_q;
  assign bus.o_fetch_count = fetch_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      pc_q  <= '0;
      pc_d  <= '0;
      hold  <= '0;
    end else if (bus.redirect_en) begin
      state <= FILL;
      pc_q  <= bus.redirect_target;
      hold  <= '0;
    end else begin
      case (state)
        FILL: begin
          state <= RUN;
          pc_d  <= pc_q;
          pc_q  <= pc_inc(pc_q);
        end
        RUN: begin
          if (bus.stall) begin
            state <= STALL;
            hold  <= bus.imem_data;
          end else begin
            pc_d  <= pc_q;
            pc_q  <= pc_inc(pc_q);
          end
        end
        STALL: begin
          if (!bus.stall) begin
            state <= RUN;
            pc_d  <= pc_q;
            pc_q  <= pc_inc(pc_q);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // An instruction counts as delivered only when decode accepts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (valid && !bus.stall) begin
      fetch_count <= 16'(fetch_count + 1'b1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM model mem[a] = a + 0x100, per-cycle
// expected outputs queued by the driver and checked by an independent monitor.
module tb_fetch_stage;

  logic clock;
  logic reset;

  fetch_if bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: data returns one cycle after the address.
  always @(posedge clock) bus.imem_data <= {20'h0, bus.imem_addr} + 32'h100;

  typedef struct {
    int          id;
    logic        v;
    logic [31:0] insn;
    logic [11:0] pcp;
    logic [11:0] addr;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("o_valid",       e.id, {31'h0, bus.o_valid},      {31'h0, e.v});
      cmp("o_insn",        e.id, bus.o_insn,                e.insn);
      cmp("o_PC_plus",     e.id, {20'h0, bus.o_PC_plus},    {20'h0, e.pcp});
      cmp("imem_addr",     e.id, {20'h0, bus.imem_addr},    {20'h0, e.addr});
      cmp("o_fetch_count", e.id, {16'h0, bus.o_fetch_count}, {16'h0, e.cnt});
    end
  end

  int step_id = 0;

  task automatic step(input logic rst_i, input logic stl, input logic red, input logic [11:0] tgt,
                      input logic v, input logic [31:0] insn, input logic [11:0] pcp,
                      input logic [11:0] addr, input logic [15:0] cnt);
    exp_t e;
    @(posedge clock);
    #1;
    reset               = rst_i;
    bus.stall           = stl;
    bus.redirect_en     = red;
    bus.redirect_target = tgt;
    e.id = step_id; e.v = v; e.insn = insn; e.pcp = pcp; e.addr = addr; e.cnt = cnt;
    exp_q.push_back(e);
    step_id++;
  endtask

  initial begin
    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.redirect_en     = 1'b0;
    bus.redirect_target = 12'h000;
    @(posedge clock);

    //   rst stl red tgt     v  insn          pcp     addr    cnt
    step(1, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'h000, 16'd0);  // 0 during reset
    step(0, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'h000, 16'd0);  // 1 boot NOP
    step(0, 0, 0, 12'h000, 1, 32'h100,      12'h001, 12'h001, 16'd0);  // 2 mem[0]
    step(0, 0, 0, 12'h000, 1, 32'h101,      12'h002, 12'h002, 16'd1);
    step(0, 0, 0, 12'h000, 1, 32'h102,      12'h003, 12'h003, 16'd2);
    step(0, 1, 0, 12'h000, 1, 32'h103,      12'h004, 12'h004, 16'd3);  // 5 stall on mem[3]
    step(0, 1, 0, 12'h000, 1, 32'h103,      12'h004, 12'h004, 16'd3);
    step(0, 1, 0, 12'h000, 1, 32'h103,      12'h004, 12'h004, 16'd3);
    step(0, 0, 0, 12'h000, 1, 32'h103,      12'h004, 12'h004, 16'd3);  // 8 stall released
    step(0, 0, 0, 12'h000, 1, 32'h104,      12'h005, 12'h005, 16'd4);  // 9 no gap, no dup
    step(0, 0, 0, 12'h000, 1, 32'h105,      12'h006, 12'h006, 16'd5);
    step(0, 0, 0, 12'h000, 1, 32'h106,      12'h007, 12'h007, 16'd6);
    step(0, 0, 1, 12'h200, 0, 32'h0,        12'h000, 12'h008, 16'd7);  // 12 squash mem[7]
    step(0, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'h200, 16'd7);  // 13 refill at 0x200
    step(0, 1, 0, 12'h000, 1, 32'h300,      12'h201, 12'h201, 16'd7);  // 14 stall mem[0x200]
    step(0, 1, 1, 12'h050, 0, 32'h0,        12'h000, 12'h201, 16'd7);  // 15 redirect beats stall
    step(0, 1, 0, 12'h000, 0, 32'h0,        12'h000, 12'h050, 16'd7);  // 16 stall ignored in FILL
    step(0, 0, 0, 12'h000, 1, 32'h150,      12'h051, 12'h051, 16'd7);  // 17 target, not held insn
    step(0, 0, 1, 12'hFFE, 0, 32'h0,        12'h000, 12'h052, 16'd8);  // 18 redirect near top
    step(0, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'hFFE, 16'd8);
    step(0, 0, 0, 12'h000, 1, 32'h10FE,     12'hFFF, 12'hFFF, 16'd8);
    step(0, 0, 0, 12'h000, 1, 32'h10FF,     12'h000, 12'h000, 16'd9);  // 21 PC+1 wraps
    step(0, 1, 0, 12'h000, 1, 32'h100,      12'h001, 12'h001, 16'd10); // 22 stall again
    step(0, 1, 0, 12'h000, 1, 32'h100,      12'h001, 12'h001, 16'd10);
    step(1, 1, 0, 12'h000, 1, 32'h100,      12'h001, 12'h001, 16'd10); // 24 reset mid-stall
    step(0, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'h000, 16'd0);  // 25 back to reset state
    step(0, 0, 0, 12'h000, 1, 32'h100,      12'h001, 12'h001, 16'd0);
    step(0, 0, 1, 12'h010, 0, 32'h0,        12'h000, 12'h002, 16'd1);  // 27 back-to-back redirects
    step(0, 0, 1, 12'h020, 0, 32'h0,        12'h000, 12'h010, 16'd1);  // 28 redirect in FILL
    step(0, 0, 0, 12'h000, 0, 32'h0,        12'h000, 12'h020, 16'd1);
    step(0, 0, 0, 12'h000, 1, 32'h120,      12'h021, 12'h021, 16'd1);

    // Give the monitor a bounded window to drain the queue.
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
